// File: rtl/nq_pkg.sv
// Shared decode-stage definitions: instruction width, NOP encoding, opcode field positions.
// Used by the prefetch queue, main control and the stall unit.
package nq_pkg;

    localparam int INST_W = 16;
    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INST_W-1:0] i);
        return i[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/nq_pfq_storage.sv
// Prefetch queue slot array: LANES-wide write at wr_ptr (slots wrap modulo DEPTH),
// single combinational read at rd_ptr.
module nq_pfq_storage
    import nq_pkg::*;
#(
    parameter int INST_W = nq_pkg::INST_W,
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [PTR_W-1:0]        wr_ptr,
    input  logic [LANES*INST_W-1:0] wr_data,
    input  logic [PTR_W-1:0]        rd_ptr,
    output logic [INST_W-1:0]       rd_data
);

    logic [INST_W-1:0] mem [DEPTH];

    // Lane k lands at wr_ptr+k; the pointer-width add wraps naturally.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                mem[wr_ptr + PTR_W'(k)] <= wr_data[k*INST_W +: INST_W];
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/nq_prefetch_queue.sv
// Circular instruction queue between instruction memory and decode; LANES-wide fill, 1-wide drain.
// Optional same-cycle bypass of an empty queue is enabled by defining NQ_PFQ_BYPASS_EN.
module nq_prefetch_queue
    import nq_pkg::*;
#(
    parameter int                INST_W   = nq_pkg::INST_W,
    parameter int                LANES    = 2,
    parameter int                DEPTH    = 8,
    parameter logic [INST_W-1:0] NOP_INST = nq_pkg::NOP_INST,
    localparam int               PTR_W    = $clog2(DEPTH),
    localparam int               CNT_W    = $clog2(DEPTH+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_valid,
    input  logic [LANES*INST_W-1:0] fetch_data,
    output logic                    fetch_ready,
    input  logic                    flush,
    input  logic                    stall,
    output logic [INST_W-1:0]       inst,
    output logic                    inst_valid,
    output logic [CNT_W-1:0]        count
);

    localparam logic [CNT_W-1:0] MAX_FILL = CNT_W'(DEPTH - LANES);
    localparam logic [CNT_W-1:0] LANES_C  = CNT_W'(LANES);
    localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(LANES);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic [INST_W-1:0] head;
    logic              push;
    logic              pop;

    // Space check uses only the registered count, so a same-cycle pop never frees room early.
    assign fetch_ready = (cnt_q <= MAX_FILL);
    assign push        = fetch_valid & fetch_ready;
    assign pop         = inst_valid & ~stall;
    assign count       = cnt_q;

    nq_pfq_storage #(
        .INST_W (INST_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push & ~flush),
        .wr_ptr  (wr_ptr),
        .wr_data (fetch_data),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    // With bypass, an empty queue forwards lane 0 directly; the word is still written in full
    // and the pop advances rd_ptr past lane 0, leaving LANES-1 entries.
    always_comb begin
        inst       = NOP_INST;
        inst_valid = 1'b0;
        if (cnt_q != '0) begin
            inst       = head;
            inst_valid = 1'b1;
        end
`ifdef NQ_PFQ_BYPASS_EN
        else if (fetch_valid && !flush) begin
            inst       = fetch_data[INST_W-1:0];
            inst_valid = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt_q <= cnt_q + (push ? LANES_C : '0) - {{(CNT_W-1){1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_nq_prefetch_queue.sv
// Self-checking bench for nq_prefetch_queue (LANES=2, DEPTH=8, INST_W=16).
// Directed stimulus plus a queue-based scoreboard monitor sampling on the falling edge.
module tb_nq_prefetch_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int INST_W = 16;
`ifdef NQ_PFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        flush;
    logic        stall;
    logic [15:0] inst;
    logic        inst_valid;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q [$];
    int          m_cnt = 0;
    logic [15:0] last_pop = '0;

    nq_prefetch_queue #(
        .INST_W   (INST_W),
        .LANES    (LANES),
        .DEPTH    (DEPTH),
        .NOP_INST (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .stall       (stall),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] fd, input logic st, input logic fl);
        fetch_valid = fv;
        fetch_data  = fd;
        stall       = st;
        flush       = fl;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
    endtask

    // Scoreboard monitor: inputs are stable between the falling edge and the next rising edge,
    // so the prediction made here is exactly what the next rising edge will do.
    always @(negedge clk) begin
        logic        byp;
        logic        e_valid;
        logic [15:0] e_inst;
        logic        m_push;
        logic        m_pop;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            byp     = BYP && (m_cnt == 0) && fetch_valid && !flush;
            e_valid = (m_cnt != 0) || byp;
            e_inst  = (m_cnt != 0) ? exp_q[0] : (byp ? fetch_data[15:0] : 16'h0000);
            checkOutput("mon_count", 32'(count), 32'(m_cnt));
            checkOutput("mon_valid", 32'(inst_valid), 32'(e_valid));
            checkOutput("mon_inst", 32'(inst), 32'(e_inst));
            checkOutput("mon_ready", 32'(fetch_ready), 32'(m_cnt <= DEPTH - LANES));
            if (inst_valid && !stall && !flush) last_pop = inst;
            m_push = fetch_valid && (m_cnt <= DEPTH - LANES) && !flush;
            m_pop  = e_valid && !stall && !flush;
            if (flush) begin
                exp_q.delete();
                m_cnt = 0;
            end else begin
                if (m_push) begin
                    exp_q.push_back(fetch_data[15:0]);
                    exp_q.push_back(fetch_data[31:16]);
                end
                if (m_pop) void'(exp_q.pop_front());
                m_cnt = m_cnt + (m_push ? LANES : 0) - (m_pop ? 1 : 0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] v;
        logic        acc;
        rst = 1'b1;
        fetch_valid = 1'b0;
        fetch_data = '0;
        flush = 1'b0;
        stall = 1'b0;
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst", 32'(inst), 32'h0000);
        checkOutput("rst_ready", 32'(fetch_ready), 32'd1);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single word through an empty queue
        applyStimulus(1'b1, 32'hBBBB_AAAA, 1'b0, 1'b0);
        checkOutput("t1_inst0", 32'(inst), BYP ? 32'hBBBB : 32'hAAAA);
        checkOutput("t1_cnt0", 32'(count), BYP ? 32'd1 : 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1_inst1", 32'(inst), BYP ? 32'h0000 : 32'hBBBB);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1_valid2", 32'(inst_valid), 32'd0);
        checkOutput("t1_inst2", 32'(inst), 32'h0000);

        // 2: fill under stall, overflow word ignored, drain in order
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, {16'(16'h1000 + 2*k + 2), 16'(16'h1000 + 2*k + 1)}, 1'b1, 1'b0);
            checkOutput("t2_fill_cnt", 32'(count), 32'(2*k + 2));
        end
        checkOutput("t2_full_ready", 32'(fetch_ready), 32'd0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        checkOutput("t2_ovf_cnt", 32'(count), 32'd8);
        checkOutput("t2_head", 32'(inst), 32'h1001);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("t2_drain_valid", 32'(inst_valid), (i < 7) ? 32'd1 : 32'd0);
            checkOutput("t2_drain_inst", 32'(inst), (i < 7) ? 32'(16'h1002 + i) : 32'h0000);
        end

        // 3: continuous fetch with 1-of-3 stall; pointers wrap several times
        v = 16'h0100;
        for (int i = 0; i < 40; i++) begin
            fetch_valid = 1'b1;
            fetch_data  = {16'(v + 16'd1), v};
            stall       = (i % 3 == 0);
            flush       = 1'b0;
            @(negedge clk);
            acc = fetch_ready;
            @(posedge clk);
            #1;
            if (acc) v = v + 16'd2;
        end
        fetch_valid = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t3_drained_cnt", 32'(count), 32'd0);
        checkOutput("t3_last_pop", 32'(last_pop), 32'(16'(v - 16'd1)));

        // 4: flush wins over same-cycle push and pop
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, {16'(16'h4000 + 2*k + 2), 16'(16'h4000 + 2*k + 1)}, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4_pre_cnt", 32'(count), 32'd5);
        applyStimulus(1'b1, 32'hF00D_CAFE, 1'b0, 1'b1);
        checkOutput("t4_cnt", 32'(count), 32'd0);
        checkOutput("t4_valid", 32'(inst_valid), 32'd0);
        checkOutput("t4_ready", 32'(fetch_ready), 32'd1);
        applyStimulus(1'b1, 32'h3002_3001, 1'b1, 1'b0);
        checkOutput("t4_refill_cnt", 32'(count), 32'd2);
        checkOutput("t4_refill_inst", 32'(inst), 32'h3001);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4_refill_inst2", 32'(inst), 32'h3002);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        // 5: asynchronous reset between clock edges
        applyStimulus(1'b1, 32'h5002_5001, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h5004_5003, 1'b1, 1'b0);
        checkOutput("t5_pre_cnt", 32'(count), 32'd4);
        #1 rst = 1'b1;
        #1;
        checkOutput("t5_rst_cnt", 32'(count), 32'd0);
        checkOutput("t5_rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("t5_rst_inst", 32'(inst), 32'h0000);
        @(negedge clk);
        #1 rst = 1'b0;
        stall = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0002_0001, 1'b0, 1'b0);
        checkOutput("t5_post_inst0", 32'(inst), BYP ? 32'h0002 : 32'h0001);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t5_post_inst1", 32'(inst), BYP ? 32'h0000 : 32'h0002);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

`ifdef NQ_PFQ_BYPASS_EN
        // 6: same-cycle bypass of an empty queue
        fetch_valid = 1'b1;
        fetch_data  = 32'h2222_1111;
        stall       = 1'b0;
        #1;
        checkOutput("t6_byp_inst", 32'(inst), 32'h1111);
        checkOutput("t6_byp_valid", 32'(inst_valid), 32'd1);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        #1;
        checkOutput("t6_next_inst", 32'(inst), 32'h2222);
        checkOutput("t6_next_cnt", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        fetch_valid = 1'b1;
        fetch_data  = 32'h2222_1111;
        stall       = 1'b1;
        #1;
        checkOutput("t6_stall_inst", 32'(inst), 32'h1111);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        checkOutput("t6_stall_cnt", 32'(count), 32'd2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
`endif

        checkOutput("final_cnt", 32'(count), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
